// File: rtl/renas_spi_pkg.sv
// Shared types and constants for the renas SPI master sequencer.
package renas_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  localparam int SS_NUM   = 4;
  localparam int SS_IDX_W = 2;

  // Active-low one-cold slave select pattern for a slave index.
  function automatic logic [SS_NUM-1:0] ss_decode(input logic [SS_IDX_W-1:0] idx);
    ss_decode = ~(SS_NUM'(1) << idx);
  endfunction

endpackage

// File: rtl/renas_spi_shifter.sv
// Serial datapath for one SPI mode-0 frame: CLK_DIV half-period divider,
// tx/rx shift registers and a rising-edge bit counter. The controller
// loads a frame on grant and tells the shifter which phase it is in.
module renas_spi_shifter #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              run,
  input  logic              xfer_en,
  input  logic [DATA_W-1:0] wdata,
  input  logic              miso_simo,
  output logic              tick,
  output logic              done,
  output logic              sclk,
  output logic              mosi_somi,
  output logic [DATA_W-1:0] rx_data
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]  div_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_sr;

  // Terminal count marks the end of each CLK_DIV-cycle phase slot.
  assign tick = run && (div_cnt == '0);
  // Last falling edge: all bits received and sclk about to drop.
  assign done = xfer_en && tick && sclk && (bit_cnt == '0);

  // Half-period down-counter, restarted on every load and terminal count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= DIV_LOAD;
    end else if (load || tick) begin
      div_cnt <= DIV_LOAD;
    end else if (run) begin
      div_cnt <= div_cnt - DIV_W'(1);
    end
  end

  // Clock generation and shifting: sample on rise, present next bit on fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk      <= 1'b0;
      mosi_somi <= 1'b0;
      tx_sr     <= '0;
      rx_data   <= '0;
      bit_cnt   <= '0;
    end else if (load) begin
      sclk      <= 1'b0;
      mosi_somi <= wdata[DATA_W-1];
      tx_sr     <= wdata << 1;
      rx_data   <= '0;
      bit_cnt   <= CNT_W'(DATA_W);
    end else if (xfer_en && tick) begin
      sclk <= ~sclk;
      if (!sclk) begin
        rx_data <= {rx_data[DATA_W-2:0], miso_simo};
        bit_cnt <= bit_cnt - CNT_W'(1);
      end else if (bit_cnt != '0) begin
        mosi_somi <= tx_sr[DATA_W-1];
        tx_sr     <= tx_sr << 1;
      end
    end
  end

endmodule

// File: rtl/renas_spi_arbiter_ctrl.sv
// Arbiter and frame sequencer for the renas SPI master port.
// Build option RENAS_SPI_RR_EN: round-robin arbitration (search starts one
// past the last grant); without it, fixed priority with lowest index winning.
//
// state | meaning
// IDLE  | ss high, waiting for a request; grant happens here
// SETUP | ss low, first bit on mosi, sclk low for CLK_DIV cycles
// XFER  | DATA_W sclk periods, sample on rise, shift on fall
// HOLD  | sclk low, ss still low for CLK_DIV cycles, then respond
module renas_spi_arbiter_ctrl
  import renas_spi_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [2*NREQ-1:0]      req_ss,
  input  logic [DATA_W*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   busy,
  output logic                   sclk,
  output logic                   mosi_somi,
  input  logic                   miso_simo,
  output logic                   ss_0,
  output logic                   ss_1,
  output logic                   ss_2,
  output logic                   ss_3
);

  localparam int OWN_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  spi_state_t           state;
  logic [OWN_W-1:0]     owner;
  logic [OWN_W-1:0]     win_idx;
  logic                 win_vld;
  logic                 grant;
  logic [SS_NUM-1:0]    ss_n;
  logic [SS_IDX_W-1:0]  sel_ss;
  logic [DATA_W-1:0]    sel_wdata;
  logic                 tick;
  logic                 done;
  logic [DATA_W-1:0]    rx_data;

`ifdef RENAS_SPI_RR_EN
  logic [OWN_W-1:0] rr_ptr;
  logic [OWN_W-1:0] cand;

  // Round-robin search starting one past the previous winner.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = OWN_W'((int'(rr_ptr) + i) % NREQ);
      if (!win_vld && req_valid[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Pointer remembers the last granted requester.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= OWN_W'(NREQ - 1);
    end else if (grant) begin
      rr_ptr <= win_idx;
    end
  end
`else
  // Fixed priority: lowest requester index wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_vld = 1'b1;
        win_idx = OWN_W'(i);
      end
    end
  end
`endif

  // The response cycle is still part of the frame, so no grant while it pulses.
  assign grant = (state == IDLE) && (rsp_valid == '0) && win_vld;

  // Combinational grant and payload mux for the winning requester.
  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready = NREQ'(1) << win_idx;
    end
    sel_ss    = req_ss[int'(win_idx)*SS_IDX_W +: SS_IDX_W];
    sel_wdata = req_wdata[int'(win_idx)*DATA_W +: DATA_W];
  end

  // Frame sequencer with registered slave selects, response and busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      ss_n      <= '1;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          busy <= grant;
          if (grant) begin
            owner <= win_idx;
            ss_n  <= ss_decode(sel_ss);
            state <= SETUP;
          end
        end
        SETUP: begin
          if (tick) state <= XFER;
        end
        XFER: begin
          if (done) state <= HOLD;
        end
        HOLD: begin
          if (tick) begin
            ss_n      <= '1;
            rsp_valid <= NREQ'(1) << owner;
            rsp_rdata <= rx_data;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  renas_spi_shifter #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (grant),
    .run       (state != IDLE),
    .xfer_en   (state == XFER),
    .wdata     (sel_wdata),
    .miso_simo (miso_simo),
    .tick      (tick),
    .done      (done),
    .sclk      (sclk),
    .mosi_somi (mosi_somi),
    .rx_data   (rx_data)
  );

  assign ss_0 = ss_n[0];
  assign ss_1 = ss_n[1];
  assign ss_2 = ss_n[2];
  assign ss_3 = ss_n[3];

endmodule

// File: tb/tb_renas_spi_arbiter_ctrl.sv
// Scoreboard bench for renas_spi_arbiter_ctrl: a CLK_DIV=4 instance with an
// SPI slave model, plus a CLK_DIV=1 instance with miso tied low.
module tb_renas_spi_arbiter_ctrl;

  localparam int NREQ = 2;
  localparam int DW   = 8;
  localparam int DIV  = 4;
  localparam int LAT  = 1 + DIV * (2 * DW + 2);
  localparam int LAT1 = 1 + 1 * (2 * DW + 2);

  typedef struct {
    int         owner;
    logic [7:0] rdata;
    logic [7:0] mosi;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [2*NREQ-1:0]    req_ss;
  logic [DW*NREQ-1:0]   req_wdata;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      rsp_valid;
  logic [DW-1:0]        rsp_rdata;
  logic                 busy, sclk, mosi, miso;
  logic                 ss_0, ss_1, ss_2, ss_3;
  logic                 ss_all;

  logic [NREQ-1:0]      req_valid1;
  logic [2*NREQ-1:0]    req_ss1;
  logic [DW*NREQ-1:0]   req_wdata1;
  logic [NREQ-1:0]      req_ready1;
  logic [NREQ-1:0]      rsp_valid1;
  logic [DW-1:0]        rsp_rdata1;
  logic                 busy1, sclk1, mosi1;
  logic                 miso1;
  logic                 ss1_0, ss1_1, ss1_2, ss1_3;

  renas_spi_arbiter_ctrl #(.NREQ(NREQ), .DATA_W(DW), .CLK_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ss(req_ss),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .busy(busy), .sclk(sclk), .mosi_somi(mosi),
    .miso_simo(miso), .ss_0(ss_0), .ss_1(ss_1), .ss_2(ss_2), .ss_3(ss_3)
  );

  renas_spi_arbiter_ctrl #(.NREQ(NREQ), .DATA_W(DW), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ss(req_ss1),
    .req_wdata(req_wdata1), .req_ready(req_ready1), .rsp_valid(rsp_valid1),
    .rsp_rdata(rsp_rdata1), .busy(busy1), .sclk(sclk1), .mosi_somi(mosi1),
    .miso_simo(miso1), .ss_0(ss1_0), .ss_1(ss1_1), .ss_2(ss1_2), .ss_3(ss1_3)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SPI slave: presents slave_pat MSB first, changes after falling sclk, captures mosi on rise.
  logic [7:0] slave_pat, slave_tx, slave_rx;
  assign ss_all = ss_0 & ss_1 & ss_2 & ss_3;
  always @(negedge ss_all) begin
    slave_tx = slave_pat;
    miso     = slave_tx[7];
    slave_rx = 8'h00;
  end
  always @(negedge sclk) begin
    slave_tx = slave_tx << 1;
    miso     = slave_tx[7];
  end
  always @(posedge sclk) slave_rx = {slave_rx[6:0], mosi};

  // Scoreboards
  int   exp_grant_q[$];
  rsp_t exp_rsp_q[$];
  int   grant_cyc[$];
  int   last_grant;
  int   g0;
  rsp_t e0;

  int   exp1_grant_q[$];
  rsp_t exp1_rsp_q[$];
  int   grant1_cnt = 0;
  int   last_grant1;
  int   rise1_cyc[$];
  logic sclk1_prev = 1'b0;
  int   g1;
  rsp_t e1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (|req_ready) begin
        if (exp_grant_q.size() == 0) chk("unexpected_grant", 32'(req_ready), 0);
        else begin
          g0 = exp_grant_q.pop_front();
          chk("grant", 32'(req_ready), 32'(1 << g0));
        end
        chk("ss_high_at_grant", 32'(ss_all), 1);
        last_grant = cyc;
        grant_cyc.push_back(cyc);
      end
      if (|rsp_valid) begin
        if (exp_rsp_q.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 0);
        else begin
          e0 = exp_rsp_q.pop_front();
          chk("rsp_owner", 32'(rsp_valid), 32'(1 << e0.owner));
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e0.rdata));
          chk("rsp_latency", 32'(cyc - last_grant), LAT);
          chk("mosi_bits", 32'(slave_rx), 32'(e0.mosi));
          chk("busy_at_rsp", 32'(busy), 1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (sclk1 && !sclk1_prev) rise1_cyc.push_back(cyc);
      sclk1_prev = sclk1;
      if (|req_ready1) begin
        if (exp1_grant_q.size() == 0) chk("div1_unexpected_grant", 32'(req_ready1), 0);
        else begin
          g1 = exp1_grant_q.pop_front();
          chk("div1_grant", 32'(req_ready1), 32'(1 << g1));
        end
        last_grant1 = cyc;
        grant1_cnt++;
      end
      if (|rsp_valid1) begin
        if (exp1_rsp_q.size() == 0) chk("div1_unexpected_rsp", 32'(rsp_valid1), 0);
        else begin
          e1 = exp1_rsp_q.pop_front();
          chk("div1_rsp_owner", 32'(rsp_valid1), 32'(1 << e1.owner));
          chk("div1_rsp_rdata", 32'(rsp_rdata1), 32'(e1.rdata));
          chk("div1_latency", 32'(cyc - last_grant1), LAT1);
        end
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic [1:0] ss, input logic [7:0] w);
    req_valid[i]       = v;
    req_ss[2*i +: 2]   = ss;
    req_wdata[8*i +: 8] = w;
  endtask

  task automatic wait_grants(input int target, input int budget, input string name);
    int n = 0;
    while (grant_cyc.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(grant_cyc.size() >= target), 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((exp_grant_q.size() != 0 || exp_rsp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(exp_grant_q.size() + exp_rsp_q.size()), 0);
  endtask

  int n0;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_ss = '0; req_wdata = '0;
    req_valid1 = '0; req_ss1 = '0; req_wdata1 = '0; miso1 = 1'b0;
    slave_pat = 8'h00; slave_tx = 8'h00; slave_rx = 8'h00; miso = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_ss", 32'({ss_3, ss_2, ss_1, ss_0}), 32'hF);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rdata", 32'(rsp_rdata), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two requesters held together
    slave_pat = 8'h96;
    n0 = grant_cyc.size();
`ifdef RENAS_SPI_RR_EN
    exp_grant_q = '{0, 1, 0, 1};
    exp_rsp_q.push_back('{owner: 0, rdata: 8'h96, mosi: 8'h81});
    exp_rsp_q.push_back('{owner: 1, rdata: 8'h96, mosi: 8'h42});
    exp_rsp_q.push_back('{owner: 0, rdata: 8'h96, mosi: 8'h81});
    exp_rsp_q.push_back('{owner: 1, rdata: 8'h96, mosi: 8'h42});
    set_req(0, 1'b1, 2'd0, 8'h81);
    set_req(1, 1'b1, 2'd1, 8'h42);
    wait_grants(n0 + 4, 400, "arb_rr_grants");
    req_valid = '0;
`else
    exp_grant_q = '{0, 0, 0, 1};
    exp_rsp_q.push_back('{owner: 0, rdata: 8'h96, mosi: 8'h81});
    exp_rsp_q.push_back('{owner: 0, rdata: 8'h96, mosi: 8'h81});
    exp_rsp_q.push_back('{owner: 0, rdata: 8'h96, mosi: 8'h81});
    exp_rsp_q.push_back('{owner: 1, rdata: 8'h96, mosi: 8'h42});
    set_req(0, 1'b1, 2'd0, 8'h81);
    set_req(1, 1'b1, 2'd1, 8'h42);
    wait_grants(n0 + 3, 300, "arb_fixed_grants");
    req_valid[0] = 1'b0;
    wait_grants(n0 + 4, 100, "arb_fixed_low_grant");
    req_valid = '0;
`endif
    wait_idle(200, "arb_drain");
    repeat (2) @(negedge clk);

    // Single frame: req 0 to slave 2
    slave_pat = 8'h3C;
    n0 = grant_cyc.size();
    exp_grant_q.push_back(0);
    exp_rsp_q.push_back('{owner: 0, rdata: 8'h3C, mosi: 8'hA5});
    set_req(0, 1'b1, 2'd2, 8'hA5);
    wait_grants(n0 + 1, 10, "single_grant_seen");
    req_valid = '0;
    repeat (10) @(negedge clk);
    chk("single_ss_pattern", 32'({ss_3, ss_2, ss_1, ss_0}), 32'b1011);
    chk("single_busy_mid", 32'(busy), 1);
    wait_idle(100, "single_drain");
    repeat (2) @(negedge clk);
    chk("single_ss_after", 32'({ss_3, ss_2, ss_1, ss_0}), 32'hF);
    chk("single_busy_after", 32'(busy), 0);

    // Back-to-back frames from requester 1
    slave_pat = 8'h69;
    n0 = grant_cyc.size();
    exp_grant_q = '{1, 1};
    exp_rsp_q.push_back('{owner: 1, rdata: 8'h69, mosi: 8'h33});
    exp_rsp_q.push_back('{owner: 1, rdata: 8'h69, mosi: 8'h33});
    set_req(1, 1'b1, 2'd1, 8'h33);
    wait_grants(n0 + 2, 200, "b2b_grants_seen");
    req_valid = '0;
    if (grant_cyc.size() >= n0 + 2)
      chk("b2b_grant_gap", 32'(grant_cyc[n0+1] - grant_cyc[n0]), LAT + 1);
    wait_idle(100, "b2b_drain");
    repeat (2) @(negedge clk);

    // Reset in the middle of a frame
    slave_pat = 8'hF0;
    n0 = grant_cyc.size();
    exp_grant_q.push_back(0);
    set_req(0, 1'b1, 2'd3, 8'h77);
    wait_grants(n0 + 1, 10, "rst_grant_seen");
    req_valid = '0;
    if (grant_cyc.size() >= n0 + 1)
      while (cyc < grant_cyc[n0] + 30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_sclk", 32'(sclk), 0);
    chk("midrst_ss", 32'({ss_3, ss_2, ss_1, ss_0}), 32'hF);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);

    slave_pat = 8'hC3;
    exp_grant_q.push_back(0);
    exp_rsp_q.push_back('{owner: 0, rdata: 8'hC3, mosi: 8'h5A});
    set_req(0, 1'b1, 2'd3, 8'h5A);
    wait_grants(grant_cyc.size() + 1, 10, "post_rst_grant_seen");
    req_valid = '0;
    wait_idle(100, "post_rst_drain");
    repeat (2) @(negedge clk);

    // Request withdrawn while busy never gets a grant
    slave_pat = 8'h5C;
    n0 = grant_cyc.size();
    exp_grant_q.push_back(1);
    exp_rsp_q.push_back('{owner: 1, rdata: 8'h5C, mosi: 8'h0F});
    set_req(1, 1'b1, 2'd0, 8'h0F);
    wait_grants(n0 + 1, 10, "wd_grant_seen");
    req_valid[1] = 1'b0;
    repeat (10) @(negedge clk);
    set_req(0, 1'b1, 2'd2, 8'hEE);
    repeat (30) @(negedge clk);
    req_valid[0] = 1'b0;
    wait_idle(100, "wd_drain");
    repeat (5) @(negedge clk);
    chk("wd_no_extra_grant", 32'(grant_cyc.size()), 32'(n0 + 1));

    // CLK_DIV=1 instance
    exp1_grant_q.push_back(0);
    exp1_rsp_q.push_back('{owner: 0, rdata: 8'h00, mosi: 8'hFF});
    req_valid1[0] = 1'b1; req_ss1[1:0] = 2'd0; req_wdata1[7:0] = 8'hFF;
    begin
      int n = 0;
      while (grant1_cnt == 0 && n < 10) begin @(negedge clk); n++; end
      req_valid1 = '0;
      n = 0;
      while (exp1_rsp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
      chk("div1_drain", 32'(exp1_rsp_q.size() + exp1_grant_q.size()), 0);
    end
    chk("div1_rise_count", 32'(rise1_cyc.size()), 8);
    if (rise1_cyc.size() >= 2)
      chk("div1_sclk_period", 32'(rise1_cyc[1] - rise1_cyc[0]), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
